// File: rtl/ifetch_queue.sv
// rtl/ifetch_queue.sv - instruction fetch queue with credit-limited requests and redirect flush
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        valid_out,
    output logic [31:0] instruction_out,
    output logic [31:0] pc_out,
    output logic [31:0] pcplus4_out
);

    localparam int          AW      = $clog2(DEPTH);
    localparam int          CW      = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_resp_pc;
    logic [31:0]   r_pc_mem  [DEPTH];
    logic [31:0]   r_ins_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_drop;

    logic [CW:0]   w_credit_sum;
    logic          w_req_fire;
    logic          w_resp_ok;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_outstanding_next;
    logic [31:0]   w_redirect_aligned;

    // Credits cover both buffered entries and in-flight requests, so a response can never overflow the FIFO.
    assign w_credit_sum       = {1'b0, r_outstanding} + {1'b0, r_count};
    assign imem_req_valid     = !rst && !redirect && (w_credit_sum < DEPTH_W);
    assign imem_req_addr      = r_fetch_pc;
    assign w_req_fire         = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored outright.
    assign w_resp_ok          = imem_resp_valid && (r_outstanding != '0);
    assign w_push             = w_resp_ok && (r_drop == '0) && !redirect;
    assign w_pop              = valid_out && !stall && !redirect;
    assign w_outstanding_next = r_outstanding + CW'(w_req_fire) - CW'(w_resp_ok);
    assign w_redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

    assign valid_out       = (r_count != '0);
    assign instruction_out = valid_out ? r_ins_mem[r_rd_ptr] : NOP;
    assign pc_out          = valid_out ? r_pc_mem[r_rd_ptr] : 32'h0;
    assign pcplus4_out     = valid_out ? (r_pc_mem[r_rd_ptr] + 32'd4) : 32'h0;

    // Fetch and response PC tracking; both restart at the aligned target on redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
        end else if (redirect) begin
            r_fetch_pc <= w_redirect_aligned;
            r_resp_pc  <= w_redirect_aligned;
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_push) begin
                r_resp_pc <= r_resp_pc + 32'd4;
            end
        end
    end

    // Outstanding and drop counters; on redirect every still-unanswered request becomes a drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_outstanding <= w_outstanding_next;
            if (redirect) begin
                r_drop <= w_outstanding_next;
            end else if (w_resp_ok && (r_drop != '0)) begin
                r_drop <= r_drop - CW'(1);
            end
        end
    end

    // FIFO pointers and occupancy; redirect empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Entry storage needs no reset: contents are only visible while occupancy is nonzero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]  <= r_resp_pc;
            r_ins_mem[r_wr_ptr] <= imem_resp_data;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb/tb_ifetch_queue.sv - directed self-checking bench for ifetch_queue
module tb_ifetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        valid_out;
    logic [31:0] instruction_out;
    logic [31:0] pc_out;
    logic [31:0] pcplus4_out;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_req    = 0;
    logic        resp_en;
    logic [31:0] pend[$];

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .stall           (stall),
        .valid_out       (valid_out),
        .instruction_out (instruction_out),
        .pc_out          (pc_out),
        .pcplus4_out     (pcplus4_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: record an accepted request, then present the next in-order response (1-cycle latency).
    task automatic tick();
        logic        acc;
        logic [31:0] a;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        @(posedge clk);
        #1;
        if (acc) begin
            pend.push_back(a);
            n_req++;
        end
        redirect = 1'b0;
        if (resp_en && pend.size() > 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = dat(pend.pop_front());
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
        #1;
    endtask

    task automatic restart(input logic st, input logic ren, input logic rdy);
        rst = 1'b1;
        pend.delete();
        imem_resp_valid = 1'b0;
        redirect = 1'b0;
        stall = st;
        resp_en = ren;
        imem_req_ready = rdy;
        #1;
        tick();
        rst = 1'b0;
        n_req = 0;
        #1;
    endtask

    initial begin
        rst = 1'b1; imem_req_ready = 1'b1; resp_en = 1'b1; stall = 1'b0;
        redirect = 1'b0; redirect_pc = 32'h0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
        #2;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_valid_out", 32'(valid_out), 32'd0);
        chk("rst_instr", instruction_out, 32'h0000_0013);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_pcp4", pcplus4_out, 32'h0);
        tick(); tick();
        rst = 1'b0; #1;

        // Back-to-back fetch with immediate responses and no stall
        chk("t1_c1_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t1_c1_addr", imem_req_addr, 32'h0);
        tick();
        chk("t1_c2_addr", imem_req_addr, 32'h4);
        chk("t1_c2_valid_out", 32'(valid_out), 32'd0);
        tick();
        chk("t1_c3_valid_out", 32'(valid_out), 32'd1);
        chk("t1_c3_pc", pc_out, 32'h0);
        chk("t1_c3_pcp4", pcplus4_out, 32'h4);
        chk("t1_c3_instr", instruction_out, dat(32'h0));
        chk("t1_c3_addr", imem_req_addr, 32'h8);
        tick();
        chk("t1_c4_pc", pc_out, 32'h4);
        chk("t1_c4_addr", imem_req_addr, 32'hC);

        // Stall holds outputs while credits run out, then drains in order
        restart(1'b1, 1'b1, 1'b1);
        tick(); tick();
        chk("t2_c3_pc", pc_out, 32'h0);
        tick(); tick();
        chk("t2_c5_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        chk("t2_c6_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t2_req_count", 32'(n_req), 32'd4);
        chk("t2_c6_valid_out", 32'(valid_out), 32'd1);
        stall = 1'b0; #1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_drain_pc", pc_out, 32'(i * 4));
            tick();
        end

        // Redirect with two responses outstanding drops both stale responses
        restart(1'b1, 1'b0, 1'b1);
        tick(); tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0103; resp_en = 1'b1; #1;
        chk("t3_redirect_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        chk("t3_c4_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t3_c4_addr", imem_req_addr, 32'h100);
        tick();
        chk("t3_c5_valid_out", 32'(valid_out), 32'd0);
        tick();
        chk("t3_c6_valid_out", 32'(valid_out), 32'd0);
        tick();
        chk("t3_c7_valid_out", 32'(valid_out), 32'd1);
        chk("t3_c7_pc", pc_out, 32'h100);
        chk("t3_c7_pcp4", pcplus4_out, 32'h104);
        chk("t3_c7_instr", instruction_out, dat(32'h100));

        // Redirect coinciding with a response and a pop
        stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0200; #1;
        chk("t4_resp_present", 32'(imem_resp_valid), 32'd1);
        chk("t4_redirect_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        chk("t4_c8_valid_out", 32'(valid_out), 32'd0);
        chk("t4_c8_instr", instruction_out, 32'h0000_0013);
        chk("t4_c8_pc", pc_out, 32'h0);
        chk("t4_c8_pcp4", pcplus4_out, 32'h0);
        chk("t4_c8_addr", imem_req_addr, 32'h200);
        tick();
        chk("t4_c9_valid_out", 32'(valid_out), 32'd0);
        tick();
        chk("t4_c10_valid_out", 32'(valid_out), 32'd1);
        chk("t4_c10_pc", pc_out, 32'h200);

        // Response with nothing outstanding is ignored without counter underflow
        restart(1'b1, 1'b0, 1'b0);
        imem_resp_valid = 1'b1; imem_resp_data = 32'h0000_0BAD; #1;
        tick();
        chk("t5_valid_out", 32'(valid_out), 32'd0);
        chk("t5_req_valid", 32'(imem_req_valid), 32'd1);
        imem_req_ready = 1'b1; #1;
        for (int i = 0; i < 6; i++) tick();
        chk("t5_credit_requests", 32'(n_req), 32'd4);
        chk("t5_req_valid_exhausted", 32'(imem_req_valid), 32'd0);

        // Redirect to the top of the address space wraps to zero
        restart(1'b1, 1'b1, 1'b1);
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF; #1;
        chk("t6_redirect_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        chk("t6_c2_addr", imem_req_addr, 32'hFFFF_FFFC);
        tick();
        chk("t6_c3_addr", imem_req_addr, 32'h0);
        tick();
        chk("t6_c4_valid_out", 32'(valid_out), 32'd1);
        chk("t6_c4_pc", pc_out, 32'hFFFF_FFFC);
        chk("t6_c4_pcp4", pcplus4_out, 32'h0);
        stall = 1'b0; #1;
        tick();
        chk("t6_c5_pc", pc_out, 32'h0);
        chk("t6_c5_pcp4", pcplus4_out, 32'h4);

        // Asynchronous reset with entries buffered and a request in flight
        restart(1'b1, 1'b1, 1'b1);
        tick(); tick(); tick(); tick();
        chk("t7_pre_valid_out", 32'(valid_out), 32'd1);
        chk("t7_pre_resp_present", 32'(imem_resp_valid), 32'd1);
        rst = 1'b1; pend.delete(); #1;
        chk("t7_rst_valid_out", 32'(valid_out), 32'd0);
        chk("t7_rst_instr", instruction_out, 32'h0000_0013);
        chk("t7_rst_pc", pc_out, 32'h0);
        chk("t7_rst_pcp4", pcplus4_out, 32'h0);
        chk("t7_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t7_rst_addr", imem_req_addr, 32'h0);
        tick(); tick();
        rst = 1'b0; #1;
        chk("t7_c1_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t7_c1_addr", imem_req_addr, 32'h0);
        tick();
        chk("t7_c2_valid_out", 32'(valid_out), 32'd0);
        tick();
        chk("t7_c3_valid_out", 32'(valid_out), 32'd1);
        chk("t7_c3_pc", pc_out, 32'h0);
        chk("t7_c3_instr", instruction_out, dat(32'h0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
